perpetual_calendar: RTL and testbench
=====================================

# perpetual_calendar

Parametrised second-resolution calendar clock: year/month/day/hour/minute/second plus day-of-week, leap-year-correct under the full Gregorian rule. Runs entirely in the `clk` domain from an internal prescaler that produces a one-cycle enable; it does not create a divided clock. Provides a validated runtime set port and a daily alarm. Sits between the board clock and the display/formatting logic.

## Interface
- `CLK_HZ`, 125_000_000: input clock frequency. One second equals `CLK_HZ` clk cycles. Must be ≥ 2.
- `YEAR_W`, 14: year width.
- `INIT_YEAR`, `INIT_MON`, `INIT_DAY`, 2022, 8, 20: date loaded at reset.
- `INIT_HOUR`, `INIT_MIN`, `INIT_SEC`, 0, 0, 0: time loaded at reset.
- `INIT_DOW`, 6: day-of-week loaded at reset. 0 = Sunday … 6 = Saturday.

- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous assert, active-low reset.
- `set_en` in 1: one-cycle request to load the `set_*` fields.
- `set_year` in YEAR_W, `set_mon` in 4, `set_day` in 5, `set_hour` in 5, `set_min` in 6, `set_sec` in 6, `set_dow` in 3: load values.
- `alarm_en` in 1: alarm enable.
- `alarm_hour` in 5, `alarm_min` in 6, `alarm_sec` in 6: alarm time.
- `year` out YEAR_W; `mon` out 4; `day` out 5; `hour` out 5; `min` out 6; `sec` out 6; `dow` out 3: current calendar state, registered.
- `leap` out 1: current `year` is a leap year (combinational from `year`).
- `sec_tick` out 1: one-cycle pulse on every second advance.
- `set_err` out 1: one-cycle pulse when a set request is rejected.
- `alarm` out 1: one-cycle alarm pulse.

## Operation
- Prescaler `pcnt` counts 0..CLK_HZ-1. Internal `tick` = (`pcnt` == CLK_HZ-1). On `tick`, `pcnt` wraps to 0.
- On `tick`, the time advances one second:
  - `sec` runs 0..59. When it wraps, `min` advances.
  - `min` runs 0..59. When it wraps, `hour` advances.
  - `hour` runs 0..23. When it wraps, `day` advances and `dow` advances 0..6 with wrap.
  - `day` runs 1..maxday, then wraps to 1 and `mon` advances.
  - `mon` runs 1..12, then wraps to 1 and `year` advances. `year` wraps from 2^YEAR_W-1 to 0 modulo 2^YEAR_W.
- maxday:
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - 30 for months 4, 6, 9, 11.
  - For month 2: 29 if leap, else 28.
  - Leap = (y%4==0 && y%100!=0) || y%400==0. maxday is always evaluated on the current register values, never on stale values.
- Set request, `set_en` = 1, is validated combinationally:
  - `set_mon` in 1..12.
  - `set_day` in 1..maxday(`set_year`, `set_mon`).
  - `set_hour` ≤ 23; `set_min` ≤ 59; `set_sec` ≤ 59; `set_dow` ≤ 6.
  - If valid: all fields load at the next edge and `pcnt` clears to 0.
  - If invalid: state and `pcnt` are unchanged and `set_err` pulses.
  - `dow` is not cross-checked against the date.
- Priority in one cycle: reset > set > tick. A valid set in a tick cycle discards the tick: no advance, no `sec_tick`.
- `alarm` pulses on the same edge as a `sec_tick` when `alarm_en` = 1 and the newly registered hour:min:sec equals the alarm time. A set never raises `alarm`.
- Reset values:
  - Calendar outputs = INIT_* parameters.
  - `pcnt` = 0.
  - `sec_tick`, `set_err`, `alarm` = 0.

## Timing
- First `sec_tick` comes CLK_HZ cycles after `rst_n` deasserts. After that, exactly one tick every CLK_HZ cycles.
- On a tick edge, every calendar field updates on that same edge. `sec_tick` and `alarm` are high for the following cycle only.
- Set latency: 1 cycle from the `set_en` sample to the new values on the outputs. After a set, the next tick comes CLK_HZ cycles later.
- `set_err` is high for the cycle after the rejected `set_en`.
- `rst_n` falling forces the reset values immediately, mid-count or mid-set. Release is synchronised externally.

## Test plan
All scenarios use `CLK_HZ` = 4.
- Reset: release `rst_n` → outputs read 2022-08-20 00:00:00, `dow` = 6. First `sec_tick` appears 4 cycles later with `sec` = 1.
- Year rollover: set 2024-12-31 23:59:59, `dow` = 2; one tick → 2025-01-01 00:00:00, `dow` = 3, `leap` = 0.
- Leap rules:
  - 2000-02-28 23:59:59 + 1 s → 2000-02-29.
  - 2100-02-28 23:59:59 + 1 s → 2100-03-01.
  - 2024-02-29 23:59:59 + 1 s → 2024-03-01.
- Invalid set: 2023-02-29 → `set_err` pulses 1 cycle, state unchanged. Also `set_hour` = 24 → `set_err` pulses. Valid 2023-02-28 → loads, `set_err` stays 0.
- Set/tick collision: assert a valid `set_en` in a tick cycle → loaded values appear exactly, no `sec_tick`; the next tick follows 4 cycles later.
- Alarm and reset: alarm 07:00:00, `alarm_en` = 1, time 06:59:58.
  - Two ticks → `alarm` pulses exactly once, together with the second `sec_tick`.
  - With `alarm_en` = 0 → no pulse.
  - Drop `rst_n` mid-count → INIT values immediately.

Source files
------------

// File: rtl/perpetual_calendar.sv
// Second-resolution Gregorian calendar clock: prescaled one-cycle enable, validated set port,
// daily alarm. All state lives in the clk domain; no derived clocks.
module perpetual_calendar #(
    parameter int unsigned CLK_HZ    = 125_000_000,
    parameter int unsigned YEAR_W    = 14,
    parameter int unsigned INIT_YEAR = 2022,
    parameter int unsigned INIT_MON  = 8,
    parameter int unsigned INIT_DAY  = 20,
    parameter int unsigned INIT_HOUR = 0,
    parameter int unsigned INIT_MIN  = 0,
    parameter int unsigned INIT_SEC  = 0,
    parameter int unsigned INIT_DOW  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [YEAR_W-1:0] set_year,
    input  logic [3:0]        set_mon,
    input  logic [4:0]        set_day,
    input  logic [4:0]        set_hour,
    input  logic [5:0]        set_min,
    input  logic [5:0]        set_sec,
    input  logic [2:0]        set_dow,
    input  logic              alarm_en,
    input  logic [4:0]        alarm_hour,
    input  logic [5:0]        alarm_min,
    input  logic [5:0]        alarm_sec,
    output logic [YEAR_W-1:0] year,
    output logic [3:0]        mon,
    output logic [4:0]        day,
    output logic [4:0]        hour,
    output logic [5:0]        min,
    output logic [5:0]        sec,
    output logic [2:0]        dow,
    output logic              leap,
    output logic              sec_tick,
    output logic              set_err,
    output logic              alarm
);

    localparam int unsigned PW = (CLK_HZ > 32'd1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PMAX = PW'(CLK_HZ - 32'd1);

    function automatic logic is_leap(input logic [YEAR_W-1:0] y);
        logic [31:0] yy;
        yy = 32'(y);
        is_leap = ((yy % 32'd4 == 32'd0) && (yy % 32'd100 != 32'd0)) || (yy % 32'd400 == 32'd0);
    endfunction

    // Returns 0 for an illegal month so any day fails validation against it.
    function automatic logic [4:0] max_day(input logic [YEAR_W-1:0] y, input logic [3:0] m);
        case (m)
            4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: max_day = 5'd31;
            4'd4, 4'd6, 4'd9, 4'd11:                    max_day = 5'd30;
            4'd2:                                       max_day = is_leap(y) ? 5'd29 : 5'd28;
            default:                                    max_day = 5'd0;
        endcase
    endfunction

    logic [PW-1:0]     pcnt_q, pcnt_d;
    logic [YEAR_W-1:0] year_q, year_d;
    logic [3:0]        mon_q, mon_d;
    logic [4:0]        day_q, day_d;
    logic [4:0]        hour_q, hour_d;
    logic [5:0]        min_q, min_d;
    logic [5:0]        sec_q, sec_d;
    logic [2:0]        dow_q, dow_d;
    logic              sec_tick_q, sec_tick_d;
    logic              set_err_q, set_err_d;
    logic              alarm_q, alarm_d;
    logic              tick_c;
    logic              set_ok_c;

    assign tick_c   = (pcnt_q == PMAX);
    assign set_ok_c = (set_mon >= 4'd1) && (set_mon <= 4'd12)
                   && (set_day >= 5'd1) && (set_day <= max_day(set_year, set_mon))
                   && (set_hour <= 5'd23) && (set_min <= 6'd59) && (set_sec <= 6'd59)
                   && (set_dow <= 3'd6);

    // Next state: a valid set overrides the tick; a rejected set leaves counting untouched.
    always_comb begin
        pcnt_d     = tick_c ? '0 : pcnt_q + PW'(1);
        year_d     = year_q;
        mon_d      = mon_q;
        day_d      = day_q;
        hour_d     = hour_q;
        min_d      = min_q;
        sec_d      = sec_q;
        dow_d      = dow_q;
        sec_tick_d = 1'b0;
        set_err_d  = 1'b0;
        alarm_d    = 1'b0;
        if (set_en && set_ok_c) begin
            pcnt_d = '0;
            year_d = set_year;
            mon_d  = set_mon;
            day_d  = set_day;
            hour_d = set_hour;
            min_d  = set_min;
            sec_d  = set_sec;
            dow_d  = set_dow;
        end else begin
            set_err_d = set_en;
            if (tick_c) begin
                sec_tick_d = 1'b1;
                if (sec_q == 6'd59) begin
                    sec_d = 6'd0;
                    if (min_q == 6'd59) begin
                        min_d = 6'd0;
                        if (hour_q == 5'd23) begin
                            hour_d = 5'd0;
                            dow_d  = (dow_q == 3'd6) ? 3'd0 : dow_q + 3'd1;
                            if (day_q >= max_day(year_q, mon_q)) begin
                                day_d = 5'd1;
                                if (mon_q == 4'd12) begin
                                    mon_d  = 4'd1;
                                    year_d = year_q + YEAR_W'(1);
                                end else begin
                                    mon_d = mon_q + 4'd1;
                                end
                            end else begin
                                day_d = day_q + 5'd1;
                            end
                        end else begin
                            hour_d = hour_q + 5'd1;
                        end
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
                alarm_d = alarm_en && (hour_d == alarm_hour) && (min_d == alarm_min)
                       && (sec_d == alarm_sec);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q     <= '0;
            year_q     <= YEAR_W'(INIT_YEAR);
            mon_q      <= 4'(INIT_MON);
            day_q      <= 5'(INIT_DAY);
            hour_q     <= 5'(INIT_HOUR);
            min_q      <= 6'(INIT_MIN);
            sec_q      <= 6'(INIT_SEC);
            dow_q      <= 3'(INIT_DOW);
            sec_tick_q <= 1'b0;
            set_err_q  <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            pcnt_q     <= pcnt_d;
            year_q     <= year_d;
            mon_q      <= mon_d;
            day_q      <= day_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            dow_q      <= dow_d;
            sec_tick_q <= sec_tick_d;
            set_err_q  <= set_err_d;
            alarm_q    <= alarm_d;
        end
    end

    assign year     = year_q;
    assign mon      = mon_q;
    assign day      = day_q;
    assign hour     = hour_q;
    assign min      = min_q;
    assign sec      = sec_q;
    assign dow      = dow_q;
    assign leap     = is_leap(year_q);
    assign sec_tick = sec_tick_q;
    assign set_err  = set_err_q;
    assign alarm    = alarm_q;

endmodule

// File: tb/tb_perpetual_calendar.sv
// Bench for perpetual_calendar at CLK_HZ=4: directed set/rollover table, corner sequences,
// and randomized traffic checked every cycle against a seconds-of-day calendar model.
module tb_perpetual_calendar;

    localparam int unsigned HZ = 4;
    localparam int unsigned YW = 14;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          set_en = 1'b0;
    logic [YW-1:0] set_year = '0;
    logic [3:0]    set_mon = '0;
    logic [4:0]    set_day = '0;
    logic [4:0]    set_hour = '0;
    logic [5:0]    set_min = '0;
    logic [5:0]    set_sec = '0;
    logic [2:0]    set_dow = '0;
    logic          alarm_en = 1'b0;
    logic [4:0]    alarm_hour = '0;
    logic [5:0]    alarm_min = '0;
    logic [5:0]    alarm_sec = '0;
    logic [YW-1:0] year;
    logic [3:0]    mon;
    logic [4:0]    day;
    logic [4:0]    hour;
    logic [5:0]    min;
    logic [5:0]    sec;
    logic [2:0]    dow;
    logic          leap;
    logic          sec_tick;
    logic          set_err;
    logic          alarm;

    perpetual_calendar #(.CLK_HZ(HZ), .YEAR_W(YW)) dut (
        .clk(clk), .rst_n(rst_n), .set_en(set_en),
        .set_year(set_year), .set_mon(set_mon), .set_day(set_day), .set_hour(set_hour),
        .set_min(set_min), .set_sec(set_sec), .set_dow(set_dow),
        .alarm_en(alarm_en), .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_sec(alarm_sec),
        .year(year), .mon(mon), .day(day), .hour(hour), .min(min), .sec(sec), .dow(dow),
        .leap(leap), .sec_tick(sec_tick), .set_err(set_err), .alarm(alarm)
    );

    initial forever #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    int m_y, m_mo, m_d, m_h, m_mi, m_s, m_w, m_p;
    int e_tick, e_err, e_alarm;

    typedef struct {
        int y, mo, d, h, mi, s, w;
        bit err;
        int ey, emo, ed, eh, emi, es, ew;
        bit el;
    } vec_t;
    vec_t tbl[$];

    function automatic int is_leap_m(int y);
        return (((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0)) ? 1 : 0;
    endfunction

    function automatic int dim(int y, int mo);
        int t[12];
        t = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (mo < 1 || mo > 12) return 0;
        if (mo == 2 && is_leap_m(y) != 0) return 29;
        return t[mo-1];
    endfunction

    function automatic vec_t mk(int y, int mo, int d, int h, int mi, int s, int w, bit err,
                                int ey, int emo, int ed, int eh, int emi, int es, int ew, bit el);
        vec_t v;
        v.y = y; v.mo = mo; v.d = d; v.h = h; v.mi = mi; v.s = s; v.w = w; v.err = err;
        v.ey = ey; v.emo = emo; v.ed = ed; v.eh = eh; v.emi = emi; v.es = es; v.ew = ew; v.el = el;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_y = 2022; m_mo = 8; m_d = 20; m_h = 0; m_mi = 0; m_s = 0; m_w = 6; m_p = 0;
        e_tick = 0; e_err = 0; e_alarm = 0;
    endtask

    function automatic bit set_valid();
        return set_mon >= 1 && set_mon <= 12 && set_day >= 1
            && int'(set_day) <= dim(int'(set_year), int'(set_mon))
            && set_hour <= 23 && set_min <= 59 && set_sec <= 59 && set_dow <= 6;
    endfunction

    // One clock edge of the calendar, using time-of-day in seconds rather than field cascades.
    task automatic model_edge();
        int sod;
        e_tick = 0; e_err = 0; e_alarm = 0;
        if (set_en && set_valid()) begin
            m_y = int'(set_year); m_mo = int'(set_mon); m_d = int'(set_day);
            m_h = int'(set_hour); m_mi = int'(set_min); m_s = int'(set_sec); m_w = int'(set_dow);
            m_p = 0;
            return;
        end
        if (set_en) e_err = 1;
        if (m_p == int'(HZ) - 1) begin
            m_p = 0;
            e_tick = 1;
            sod = m_h * 3600 + m_mi * 60 + m_s + 1;
            if (sod == 86400) begin
                sod = 0;
                m_w = (m_w + 1) % 7;
                m_d++;
                if (m_d > dim(m_y, m_mo)) begin
                    m_d = 1;
                    m_mo++;
                    if (m_mo > 12) begin
                        m_mo = 1;
                        m_y = (m_y + 1) % (1 << YW);
                    end
                end
            end
            m_h = sod / 3600; m_mi = (sod / 60) % 60; m_s = sod % 60;
            e_alarm = (alarm_en && m_h == int'(alarm_hour) && m_mi == int'(alarm_min)
                       && m_s == int'(alarm_sec)) ? 1 : 0;
        end else begin
            m_p++;
        end
    endtask

    task automatic compare_all();
        chk("year", int'(year), m_y);
        chk("mon", int'(mon), m_mo);
        chk("day", int'(day), m_d);
        chk("hour", int'(hour), m_h);
        chk("min", int'(min), m_mi);
        chk("sec", int'(sec), m_s);
        chk("dow", int'(dow), m_w);
        chk("leap", int'(leap), is_leap_m(m_y));
        chk("sec_tick", int'(sec_tick), e_tick);
        chk("set_err", int'(set_err), e_err);
        chk("alarm", int'(alarm), e_alarm);
    endtask

    task automatic cyc();
        if (!rst_n) model_reset(); else model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic drive_set(input int y, input int mo, input int d, input int h, input int mi,
                             input int s, input int w);
        set_en = 1'b1;
        set_year = YW'(y); set_mon = 4'(mo); set_day = 5'(d);
        set_hour = 5'(h); set_min = 6'(mi); set_sec = 6'(s); set_dow = 3'(w);
        cyc();
        set_en = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int py, pmo, pd, ph, pmi, ps, pw;
        py = m_y; pmo = m_mo; pd = m_d; ph = m_h; pmi = m_mi; ps = m_s; pw = m_w;
        drive_set(v.y, v.mo, v.d, v.h, v.mi, v.s, v.w);
        chk("tbl_set_err", int'(set_err), int'(v.err));
        if (v.err) begin
            chk("hold_year", int'(year), py); chk("hold_mon", int'(mon), pmo);
            chk("hold_day", int'(day), pd);   chk("hold_hour", int'(hour), ph);
            chk("hold_min", int'(min), pmi);  chk("hold_sec", int'(sec), ps);
            chk("hold_dow", int'(dow), pw);
        end else begin
            chk("load_year", int'(year), v.y); chk("load_day", int'(day), v.d);
            chk("load_sec", int'(sec), v.s);   chk("load_dow", int'(dow), v.w);
            for (int i = 0; i < 3; i++) begin
                cyc();
                chk("tbl_no_tick", int'(sec_tick), 0);
            end
            cyc();
            chk("tbl_tick", int'(sec_tick), 1);
            chk("tbl_year", int'(year), v.ey); chk("tbl_mon", int'(mon), v.emo);
            chk("tbl_day", int'(day), v.ed);   chk("tbl_hour", int'(hour), v.eh);
            chk("tbl_min", int'(min), v.emi);  chk("tbl_sec", int'(sec), v.es);
            chk("tbl_dow", int'(dow), v.ew);   chk("tbl_leap", int'(leap), int'(v.el));
        end
    endtask

    task automatic async_reset();
        set_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic rand_inputs();
        int y, mo;
        set_en = ($urandom_range(0, 7) == 0);
        y = ($urandom_range(0, 9) == 0) ? 16383 : int'($urandom_range(1890, 2410));
        mo = int'($urandom_range(0, 13));
        set_year = YW'(y);
        set_mon = 4'(mo);
        if ($urandom_range(0, 1) == 1) set_day = 5'(dim(y, mo));
        else set_day = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 1) == 1) begin
            set_hour = 5'd23; set_min = 6'd59; set_sec = 6'($urandom_range(57, 60));
        end else begin
            set_hour = 5'($urandom_range(0, 24));
            set_min = 6'($urandom_range(0, 60));
            set_sec = 6'($urandom_range(0, 60));
        end
        set_dow = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 15) == 0) begin
            alarm_en = ($urandom_range(0, 3) != 0);
            alarm_hour = 5'(m_h);
            alarm_min = 6'(m_mi);
            alarm_sec = 6'((m_s + int'($urandom_range(1, 2))) % 60);
        end
    endtask

    initial begin
        int cnt;
        tbl.push_back(mk(2024, 12, 31, 23, 59, 59, 2, 0, 2025, 1, 1, 0, 0, 0, 3, 0));
        tbl.push_back(mk(2000, 2, 28, 23, 59, 59, 1, 0, 2000, 2, 29, 0, 0, 0, 2, 1));
        tbl.push_back(mk(2023, 2, 29, 10, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2023, 5, 10, 24, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2100, 2, 28, 23, 59, 59, 0, 0, 2100, 3, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(2023, 13, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2023, 4, 31, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2024, 2, 29, 23, 59, 59, 4, 0, 2024, 3, 1, 0, 0, 0, 5, 1));
        tbl.push_back(mk(2023, 2, 28, 12, 34, 56, 2, 0, 2023, 2, 28, 12, 34, 57, 2, 0));
        tbl.push_back(mk(2023, 6, 1, 12, 0, 60, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2023, 6, 1, 12, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(16383, 12, 31, 23, 59, 59, 5, 0, 0, 1, 1, 0, 0, 0, 6, 1));
        tbl.push_back(mk(1900, 2, 28, 23, 59, 59, 3, 0, 1900, 3, 1, 0, 0, 0, 4, 0));
        tbl.push_back(mk(2023, 9, 30, 23, 59, 59, 6, 0, 2023, 10, 1, 0, 0, 0, 0, 0));

        // Reset values and first-tick latency
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_year", int'(year), 2022); chk("rst_mon", int'(mon), 8);
        chk("rst_day", int'(day), 20);     chk("rst_dow", int'(dow), 6);
        chk("rst_hms", int'({hour, min, sec}), 0);
        chk("rst_pulses", int'({sec_tick, set_err, alarm}), 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("first_tick", int'(sec_tick), (i == 3) ? 1 : 0);
        end
        chk("first_sec", int'(sec), 1);

        foreach (tbl[i]) run_vec(tbl[i]);

        // Valid set landing on a tick edge: set wins, tick discarded, count restarts
        for (int i = 0; i < 3; i++) cyc();
        drive_set(2030, 6, 15, 10, 20, 30, 6);
        chk("coll_no_tick", int'(sec_tick), 0);
        chk("coll_sec", int'(sec), 30);
        chk("coll_min", int'(min), 20);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("coll_next_tick", int'(sec_tick), (i == 3) ? 1 : 0);
        end
        chk("coll_sec_after", int'(sec), 31);

        // Alarm: a set to the alarm time never fires; two ticks from 06:59:58 fire once
        alarm_en = 1'b1; alarm_hour = 5'd7; alarm_min = 6'd0; alarm_sec = 6'd0;
        drive_set(2022, 8, 20, 7, 0, 0, 6);
        chk("alarm_on_set", int'(alarm), 0);
        drive_set(2022, 8, 20, 6, 59, 58, 6);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (alarm) cnt++;
            if (i == 7) begin
                chk("alarm_pulse", int'(alarm), 1);
                chk("alarm_with_tick", int'(sec_tick), 1);
                chk("alarm_hour", int'(hour), 7);
            end
        end
        chk("alarm_count", cnt, 1);
        alarm_en = 1'b0;
        drive_set(2022, 8, 20, 6, 59, 58, 6);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (alarm) cnt++;
        end
        chk("alarm_disabled", cnt, 0);

        // Reset dropped mid-count takes effect without a clock edge
        cyc();
        cyc();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_year", int'(year), 2022); chk("mid_rst_mon", int'(mon), 8);
        chk("mid_rst_day", int'(day), 20);     chk("mid_rst_hms", int'({hour, min, sec}), 0);
        chk("mid_rst_dow", int'(dow), 6);      chk("mid_rst_tick", int'(sec_tick), 0);
        cyc();
        rst_n = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 699) == 0) begin
                async_reset();
            end else begin
                rand_inputs();
                cyc();
            end
        end
        set_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
